conv_sa_acc_row: RTL and testbench

Parametrised accumulation row for the convolution systolic array: P columns, each holding a DEPTH-entry, two-lane accumulator bank. Each column adds signed partial sums from the PE array into the addressed entry and emits the finished sums on the last round. Control flags enter at column 0 and ripple one column per cycle, matching the skew of the incoming psum data. It generalises the fixed 8-entry, wrap-only sum row with configurable widths and depth, first-round clear, optional saturation with sticky overflow, and a per-column output valid.

---
 rtl/conv_sa_acc_row.sv | 137 +++++++++++++
 tb/tb_conv_sa_acc_row.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sa_acc_row.sv
// Accumulation row for the conv systolic array: P skewed columns, each a
// DEPTH-entry two-lane signed accumulator bank with wrap or saturate.
module conv_sa_acc_row #(
  parameter int P      = 16,
  parameter int PSUM_W = 19,
  parameter int SUM_W  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int SAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [P*PSUM_W-1:0]   in_psum1,
  input  logic [P*PSUM_W-1:0]   in_psum2,
  input  logic                  in_psum_vld,
  input  logic                  in_psum_first_rnd,
  input  logic                  in_psum_last_rnd,
  input  logic [ADDR_W-1:0]     in_psum_wr_addr,
  output logic [P*SUM_W-1:0]    out_sum1,
  output logic [P*SUM_W-1:0]    out_sum2,
  output logic [P-1:0]          out_vld,
  output logic [P*ADDR_W-1:0]   out_addr,
  output logic [P-1:0]          out_ovf
);

  localparam logic [SUM_W-1:0] SMAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SMIN = {1'b1, {(SUM_W-1){1'b0}}};
  localparam int EXT_W = SUM_W + 1 - PSUM_W;

  logic [P-1:0]      st_vld;
  logic [P-1:0]      st_first;
  logic [P-1:0]      st_last;
  logic [ADDR_W-1:0] st_addr [P];

  assign st_vld[0]   = in_psum_vld;
  assign st_first[0] = in_psum_first_rnd;
  assign st_last[0]  = in_psum_last_rnd;
  assign st_addr[0]  = in_psum_wr_addr;

  // Flags ripple one column per cycle to track the psum skew.
  for (genvar k = 1; k < P; k++) begin : g_stg
    logic              vld_q;
    logic              first_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q   <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
        addr_q  <= '0;
      end else begin
        vld_q   <= st_vld[k-1];
        first_q <= st_first[k-1];
        last_q  <= st_last[k-1];
        addr_q  <= st_addr[k-1];
      end
    end

    assign st_vld[k]   = vld_q;
    assign st_first[k] = first_q;
    assign st_last[k]  = last_q;
    assign st_addr[k]  = addr_q;
  end

  for (genvar i = 0; i < P; i++) begin : g_col
    logic [SUM_W-1:0]  acc1_q [DEPTH];
    logic [SUM_W-1:0]  acc2_q [DEPTH];
    logic [PSUM_W-1:0] p1;
    logic [PSUM_W-1:0] p2;
    logic [SUM_W-1:0]  a1;
    logic [SUM_W-1:0]  a2;
    logic [SUM_W:0]    s1;
    logic [SUM_W:0]    s2;
    logic              o1;
    logic              o2;
    logic [SUM_W-1:0]  r1;
    logic [SUM_W-1:0]  r2;
    logic [SUM_W-1:0]  sum1_q;
    logic [SUM_W-1:0]  sum2_q;
    logic [ADDR_W-1:0] addr_q;
    logic              vld_q;
    logic              ovf_q;

    assign p1 = in_psum1[i*PSUM_W +: PSUM_W];
    assign p2 = in_psum2[i*PSUM_W +: PSUM_W];

    assign a1 = st_first[i] ? '0 : acc1_q[st_addr[i]];
    assign a2 = st_first[i] ? '0 : acc2_q[st_addr[i]];

    assign s1 = {a1[SUM_W-1], a1} + {{EXT_W{p1[PSUM_W-1]}}, p1};
    assign s2 = {a2[SUM_W-1], a2} + {{EXT_W{p2[PSUM_W-1]}}, p2};

    // Top two bits differ only when the true sum left the SUM_W range.
    assign o1 = s1[SUM_W] ^ s1[SUM_W-1];
    assign o2 = s2[SUM_W] ^ s2[SUM_W-1];

    assign r1 = (SAT != 0 && o1) ? (s1[SUM_W] ? SMIN : SMAX)
                                 : s1[SUM_W-1:0];
    assign r2 = (SAT != 0 && o2) ? (s2[SUM_W] ? SMIN : SMAX)
                                 : s2[SUM_W-1:0];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < DEPTH; j++) begin
          acc1_q[j] <= '0;
          acc2_q[j] <= '0;
        end
        sum1_q <= '0;
        sum2_q <= '0;
        addr_q <= '0;
        vld_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        vld_q <= st_vld[i] & st_last[i];
        if (st_vld[i]) begin
          acc1_q[st_addr[i]] <= r1;
          acc2_q[st_addr[i]] <= r2;
          if (st_last[i]) begin
            sum1_q <= r1;
            sum2_q <= r2;
            addr_q <= st_addr[i];
          end
          if (SAT != 0 && (o1 || o2)) ovf_q <= 1'b1;
        end
      end
    end

    assign out_sum1[i*SUM_W +: SUM_W]   = sum1_q;
    assign out_sum2[i*SUM_W +: SUM_W]   = sum2_q;
    assign out_addr[i*ADDR_W +: ADDR_W] = addr_q;
    assign out_vld[i]                   = vld_q;
    assign out_ovf[i]                   = ovf_q;
  end

endmodule

// File: tb/tb_conv_sa_acc_row.sv
// Scoreboard bench for conv_sa_acc_row: skewed psum driver, per-column
// expected-result queues, plus wrap/saturate instances with 32-bit psums.
module tb_conv_sa_acc_row;

  localparam int P  = 4;
  localparam int PW = 19;
  localparam int SW = 32;
  localparam int WP = 32;

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [2:0]  a;
    int          c;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic [P*PW-1:0] in_psum1, in_psum2;
  logic            in_psum_vld, in_psum_first_rnd, in_psum_last_rnd;
  logic [2:0]      in_psum_wr_addr;
  logic [P*SW-1:0] out_sum1, out_sum2;
  logic [P-1:0]    out_vld, out_ovf;
  logic [P*3-1:0]  out_addr;

  logic [P*WP-1:0] w_psum1, w_psum2;
  logic            w_vld, w_first, w_last;
  logic [2:0]      w_addr;
  logic [P*SW-1:0] wr_sum1, wr_sum2, st_sum1, st_sum2;
  logic [P-1:0]    wr_vld, wr_ovf, st_vld, st_ovf;
  logic [P*3-1:0]  wr_addr, st_addr;

  int               sch1 [64][4];
  int               sch2 [64][4];
  int               wsch1 [64][4];
  int               wsch2 [64][4];
  logic signed [31:0] macc1 [4][8];
  logic signed [31:0] macc2 [4][8];
  exp_t             sbq [4][$];

  conv_sa_acc_row #(.P(P), .PSUM_W(PW), .SUM_W(SW), .DEPTH(8), .SAT(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_psum1(in_psum1), .in_psum2(in_psum2),
    .in_psum_vld(in_psum_vld), .in_psum_first_rnd(in_psum_first_rnd),
    .in_psum_last_rnd(in_psum_last_rnd), .in_psum_wr_addr(in_psum_wr_addr),
    .out_sum1(out_sum1), .out_sum2(out_sum2), .out_vld(out_vld),
    .out_addr(out_addr), .out_ovf(out_ovf)
  );

  conv_sa_acc_row #(.P(P), .PSUM_W(WP), .SUM_W(SW), .DEPTH(8), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst),
    .in_psum1(w_psum1), .in_psum2(w_psum2),
    .in_psum_vld(w_vld), .in_psum_first_rnd(w_first),
    .in_psum_last_rnd(w_last), .in_psum_wr_addr(w_addr),
    .out_sum1(wr_sum1), .out_sum2(wr_sum2), .out_vld(wr_vld),
    .out_addr(wr_addr), .out_ovf(wr_ovf)
  );

  conv_sa_acc_row #(.P(P), .PSUM_W(WP), .SUM_W(SW), .DEPTH(8), .SAT(1)) u_sat (
    .clk(clk), .rst(rst),
    .in_psum1(w_psum1), .in_psum2(w_psum2),
    .in_psum_vld(w_vld), .in_psum_first_rnd(w_first),
    .in_psum_last_rnd(w_last), .in_psum_wr_addr(w_addr),
    .out_sum1(st_sum1), .out_sum2(st_sum2), .out_vld(st_vld),
    .out_addr(st_addr), .out_ovf(st_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < P; i++) begin
      if (out_vld[i] === 1'b1) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("vld_unexp[%0d]", i), 32'(out_vld[i]), 32'd0);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          chk($sformatf("sum1[%0d]", i), out_sum1[i*SW +: SW], e.s1);
          chk($sformatf("sum2[%0d]", i), out_sum2[i*SW +: SW], e.s2);
          chk($sformatf("addr[%0d]", i), 32'(out_addr[i*3 +: 3]), 32'(e.a));
          chk($sformatf("vld_cyc[%0d]", i), cyc, e.c);
        end
      end
    end
  end

  task automatic step();
    int s;
    s = cyc % 64;
    for (int i = 0; i < P; i++) begin
      in_psum1[i*PW +: PW] = sch1[s][i][PW-1:0];
      in_psum2[i*PW +: PW] = sch2[s][i][PW-1:0];
      w_psum1[i*WP +: WP]  = wsch1[s][i];
      w_psum2[i*WP +: WP]  = wsch2[s][i];
    end
    @(posedge clk);
    #1;
    in_psum_vld = 1'b0;
    in_psum_first_rnd = 1'b0;
    in_psum_last_rnd = 1'b0;
    w_vld = 1'b0;
    w_first = 1'b0;
    w_last = 1'b0;
  endtask

  task automatic issue_main(input logic f, input logic l, input logic [2:0] ad,
                            input int p1 [4], input int p2 [4]);
    logic signed [31:0] a1, a2;
    exp_t e;
    in_psum_vld = 1'b1;
    in_psum_first_rnd = f;
    in_psum_last_rnd = l;
    in_psum_wr_addr = ad;
    for (int i = 0; i < P; i++) begin
      sch1[(cyc + i) % 64][i] = p1[i];
      sch2[(cyc + i) % 64][i] = p2[i];
      a1 = f ? 32'sd0 : macc1[i][ad];
      a2 = f ? 32'sd0 : macc2[i][ad];
      a1 = a1 + p1[i];
      a2 = a2 + p2[i];
      macc1[i][ad] = a1;
      macc2[i][ad] = a2;
      if (l) begin
        e.s1 = a1;
        e.s2 = a2;
        e.a  = ad;
        e.c  = cyc + 1 + i;
        sbq[i].push_back(e);
      end
    end
  endtask

  task automatic issue_u(input logic f, input logic l, input logic [2:0] ad,
                         input int v1, input int v2);
    int p1 [4];
    int p2 [4];
    for (int i = 0; i < P; i++) begin
      p1[i] = v1;
      p2[i] = v2;
    end
    issue_main(f, l, ad, p1, p2);
  endtask

  task automatic issue_wide(input logic f, input logic l, input logic [2:0] ad,
                            input int v1, input int v2);
    w_vld = 1'b1;
    w_first = f;
    w_last = l;
    w_addr = ad;
    for (int i = 0; i < P; i++) begin
      wsch1[(cyc + i) % 64][i] = v1;
      wsch2[(cyc + i) % 64][i] = v2;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < P; i++) begin
      chk({tag, "_sum1"}, out_sum1[i*SW +: SW], 32'd0);
      chk({tag, "_sum2"}, out_sum2[i*SW +: SW], 32'd0);
      chk({tag, "_addr"}, 32'(out_addr[i*3 +: 3]), 32'd0);
    end
    chk({tag, "_vld"}, 32'(out_vld), 32'd0);
    chk({tag, "_ovf"}, 32'(st_ovf), 32'd0);
  endtask

  initial begin
    int p1 [4];
    int p2 [4];
    logic signed [18:0] r19;

    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    in_psum_vld = 1'b0;
    in_psum_first_rnd = 1'b0;
    in_psum_last_rnd = 1'b0;
    in_psum_wr_addr = '0;
    w_vld = 1'b0;
    w_first = 1'b0;
    w_last = 1'b0;
    w_addr = '0;
    in_psum1 = '0;
    in_psum2 = '0;
    w_psum1 = '0;
    w_psum2 = '0;
    for (int s = 0; s < 64; s++)
      for (int i = 0; i < P; i++) begin
        sch1[s][i] = 0;
        sch2[s][i] = 0;
        wsch1[s][i] = 0;
        wsch2[s][i] = 0;
      end
    for (int i = 0; i < P; i++)
      for (int a = 0; a < 8; a++) begin
        macc1[i][a] = 0;
        macc2[i][a] = 0;
      end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("rst");

    // single round, per-column values
    for (int i = 0; i < P; i++) begin
      p1[i] = i + 1;
      p2[i] = -(i + 1);
    end
    issue_main(1'b1, 1'b1, 3'd3, p1, p2);
    step();
    repeat (6) step();

    // interleaved accumulation on addr 5 and addr 6
    for (int r = 0; r < 4; r++) begin
      issue_u(r == 0, r == 3, 3'd5, 100, 3);
      step();
      issue_u(r == 0, r == 3, 3'd6, -7, -100);
      step();
    end
    repeat (6) step();

    // first round overwrites a stale entry, chained back-to-back
    issue_u(1'b1, 1'b1, 3'd2, 999, -999);
    step();
    issue_u(1'b1, 1'b0, 3'd2, 10, 20);
    step();
    issue_u(1'b0, 1'b1, 3'd2, 1, -2);
    step();
    repeat (6) step();

    // wrap vs saturate
    issue_wide(1'b1, 1'b0, 3'd1, 32'h7fff_ffff, 1);
    step();
    issue_wide(1'b0, 1'b1, 3'd1, 5, 2);
    step();
    repeat (6) step();
    for (int i = 0; i < P; i++) begin
      chk("wrap_sum1", wr_sum1[i*SW +: SW], 32'h8000_0004);
      chk("wrap_sum2", wr_sum2[i*SW +: SW], 32'd3);
      chk("sat_sum1", st_sum1[i*SW +: SW], 32'h7fff_ffff);
      chk("sat_sum2", st_sum2[i*SW +: SW], 32'd3);
    end
    chk("wrap_ovf", 32'(wr_ovf), 32'd0);
    chk("sat_ovf", 32'(st_ovf), 32'hf);
    issue_wide(1'b1, 1'b1, 3'd1, 1, -1);
    step();
    repeat (6) step();
    for (int i = 0; i < P; i++)
      chk("sat_after", st_sum1[i*SW +: SW], 32'd1);
    chk("sat_ovf_sticky", 32'(st_ovf), 32'hf);

    // reset one cycle after a last round
    issue_u(1'b1, 1'b1, 3'd4, 50, 60);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < P; i++) begin
      sbq[i].delete();
      for (int a = 0; a < 8; a++) begin
        macc1[i][a] = 0;
        macc2[i][a] = 0;
      end
    end
    check_zero("midrst");
    step();
    issue_u(1'b1, 1'b1, 3'd7, -11, 12);
    step();
    repeat (6) step();

    // toggling valid: every output must land exactly i cycles after col 0
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        for (int i = 0; i < P; i++) begin
          r19 = 19'($urandom);
          p1[i] = r19;
          r19 = 19'($urandom);
          p2[i] = r19;
        end
        issue_main(1'b1, 1'b1, 3'(k), p1, p2);
      end
      step();
    end
    repeat (8) step();

    for (int i = 0; i < P; i++)
      chk($sformatf("sb_left[%0d]", i), sbq[i].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
